// File: rtl/pulsador_pkg.sv
// Shared state encoding, repeat-counter width/limit and saturating increment
// for the key-event block.
package pulsador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;
  localparam logic [1:0] ST_HELD = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAIT    = ST_WAIT,
    RPT     = ST_RPT,
    HELD_ST = ST_HELD
  } state_e;

  localparam int unsigned REP_CNT_W = 8;
  localparam logic [REP_CNT_W-1:0] REP_CNT_MAX = 8'd255;

  function automatic logic [REP_CNT_W-1:0] sat_inc(input logic [REP_CNT_W-1:0] v);
    return (v == REP_CNT_MAX) ? v : v + REP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulsador_eventos_detector_flanco.sv
// Registers the debounced level and derives rise/fall strobes against the
// registered copy.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic da,
  output logic held,
  output logic rise_c,
  output logic fall_c
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = da;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign held   = d_q;
  assign rise_c = da & ~d_q;
  assign fall_c = ~da & d_q;

endmodule

// File: rtl/pulsador_eventos.sv
// Turns a debounced button level into press/repeat/release pulses and a
// saturating repeat count. Auto-repeat is built only with PULSADOR_AUTOREPEAT_EN.
module pulsador_eventos
  import pulsador_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 50_000_000,
  parameter int unsigned RATE_CYCLES  = 10_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 DA,
  output logic                 PRESS,
  output logic                 REPEAT,
  output logic                 RELEASE,
  output logic                 HELD,
  output logic [REP_CNT_W-1:0] REP_CNT
);

  localparam int unsigned MAX_CYC = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;

  // Elaboration guard on the timing parameters.
  if (DELAY_CYCLES < 2 || RATE_CYCLES < 1 || CNT_W > 63 ||
      (64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_bad_cfg
    $error("pulsador_eventos: invalid DELAY_CYCLES/RATE_CYCLES/CNT_W");
  end

  logic rise_c;
  logic fall_c;

  detector_flanco u_detector_flanco (
    .clk    (CLK),
    .rst_n  (RST_N),
    .da     (DA),
    .held   (HELD),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  state_e                 state_q,   state_d;
  logic                   press_q,   press_d;
  logic                   repeat_q,  repeat_d;
  logic                   release_q, release_d;
  logic [REP_CNT_W-1:0]   rep_cnt_q, rep_cnt_d;

`ifdef PULSADOR_AUTOREPEAT_EN
  logic [CNT_W-1:0] timer_q, timer_d;

  // Release beats a simultaneous timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    rep_cnt_d = rep_cnt_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rise_c) begin
          press_d   = 1'b1;
          rep_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (fall_c) begin
          release_d = 1'b1;
          timer_d   = '0;
          state_d   = IDLE;
        end else if (timer_q == CNT_W'(DELAY_CYCLES - 1)) begin
          repeat_d  = 1'b1;
          rep_cnt_d = sat_inc(rep_cnt_q);
          timer_d   = '0;
          state_d   = RPT;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RPT: begin
        if (fall_c) begin
          release_d = 1'b1;
          timer_d   = '0;
          state_d   = IDLE;
        end else if (timer_q == CNT_W'(RATE_CYCLES - 1)) begin
          repeat_d  = 1'b1;
          rep_cnt_d = sat_inc(rep_cnt_q);
          timer_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  // Without auto-repeat the block only tracks pressed/released.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    rep_cnt_d = '0;
    unique case (state_q)
      IDLE: begin
        if (rise_c) begin
          press_d = 1'b1;
          state_d = HELD_ST;
        end
      end
      HELD_ST: begin
        if (fall_c) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign PRESS   = press_q;
  assign REPEAT  = repeat_q;
  assign RELEASE = release_q;
  assign REP_CNT = rep_cnt_q;

endmodule

// File: tb/tb_pulsador_eventos.sv
// Bench for pulsador_eventos: directed scenarios plus random button activity,
// checked every cycle against an edge-counting model.
module tb_pulsador_eventos;

  localparam int unsigned D = 10;
  localparam int unsigned R = 4;
`ifdef PULSADOR_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       da;
  logic       press;
  logic       rpt;
  logic       rel;
  logic       held;
  logic [7:0] rep_cnt;

  pulsador_eventos #(
    .DELAY_CYCLES (D),
    .RATE_CYCLES  (R),
    .CNT_W        (8)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .DA      (da),
    .PRESS   (press),
    .REPEAT  (rpt),
    .RELEASE (rel),
    .HELD    (held),
    .REP_CNT (rep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: previous level, edges held since the press edge, repeat count.
  bit e_press = 0, e_rep = 0, e_rel = 0, e_held = 0;
  int m_cnt = 0;
  bit m_d = 0;
  int m_k = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      e_press = 0; e_rep = 0; e_rel = 0; e_held = 0;
      m_cnt = 0; m_d = 0; m_k = 0;
    end else begin
      e_press = da && !m_d;
      e_rel   = !da && m_d;
      e_rep   = 0;
      if (e_press) begin
        m_k = 0;
        m_cnt = 0;
      end else if (da && m_d) begin
        m_k++;
        if (AUTO && m_k >= int'(D) && ((m_k - int'(D)) % int'(R)) == 0) begin
          e_rep = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      e_held = da;
      m_d = da;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [11:0] act, exp;
    act = {press, rpt, rel, held, rep_cnt};
    exp = {e_press, e_rep, e_rel, e_held, 8'(m_cnt)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t: got press=%b rep=%b rel=%b held=%b cnt=%0d expected press=%b rep=%b rel=%b held=%b cnt=%0d",
               $time, press, rpt, rel, held, rep_cnt, e_press, e_rep, e_rel, e_held, m_cnt);
    end
  end

  int rep_seen = 0;
  always @(negedge clk) if (rpt === 1'b1) rep_seen++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles, settling just after the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    da    = 1'b1;
    cyc(3);
    chk("reset_outputs", int'({press, rpt, rel, held, rep_cnt}), 0);

    // Reset released with the button held: fresh press, then a long hold.
    rst_n = 1'b1;
    rep_seen = 0;
    cyc(1);
    chk("reset_press", int'(press), 1);
    cyc(29);
    da = 1'b0;
    cyc(1);
    chk("long_release", int'(rel), 1);
    chk("long_rep_pulses", rep_seen, AUTO ? 5 : 0);
    chk("long_rep_cnt", int'(rep_cnt), AUTO ? 5 : 0);
    cyc(3);
    chk("cnt_holds_after_release", int'(rep_cnt), AUTO ? 5 : 0);

    // Short press of 5 cycles.
    rep_seen = 0;
    da = 1'b1;
    cyc(1);
    chk("short_press", int'(press), 1);
    chk("short_cnt_cleared", int'(rep_cnt), 0);
    cyc(4);
    da = 1'b0;
    cyc(1);
    chk("short_release", int'(rel), 1);
    chk("short_no_repeat", rep_seen, 0);
    cyc(3);

    // Release exactly on the first repeat expiry.
    rep_seen = 0;
    da = 1'b1;
    cyc(10);
    da = 1'b0;
    cyc(1);
    chk("collide_release", int'(rel), 1);
    chk("collide_no_repeat", int'(rpt), 0);
    chk("collide_cnt", int'(rep_cnt), 0);
    chk("collide_pulses", rep_seen, 0);
    cyc(3);

    // Saturation: 10 + 4*300 held edges.
    rep_seen = 0;
    da = 1'b1;
    cyc(1210);
    chk("sat_cnt", int'(rep_cnt), AUTO ? 255 : 0);
    chk("sat_pulses", rep_seen, AUTO ? 300 : 0);
    da = 1'b0;
    cyc(1);
    chk("sat_release", int'(rel), 1);
    cyc(2);

    // One-cycle glitch.
    da = 1'b1;
    cyc(1);
    da = 1'b0;
    chk("glitch_press", int'(press), 1);
    cyc(1);
    chk("glitch_release", int'(rel), 1);
    cyc(2);

    // Reset mid-hold: no release, fresh press afterwards.
    da = 1'b1;
    cyc(12);
    rst_n = 1'b0;
    cyc(2);
    chk("midhold_reset_quiet", int'({press, rpt, rel, rep_cnt}), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("midhold_fresh_press", int'(press), 1);
    chk("midhold_no_release", int'(rel), 0);
    da = 1'b0;
    cyc(2);

    // Random button activity with occasional resets.
    for (int i = 0; i < 200; i++) begin
      da = ~da;
      if ($urandom_range(0, 9) == 0) cyc($urandom_range(30, 60));
      else cyc($urandom_range(1, 25));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    da = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
